rom_loader: RTL

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/icehack_pkg.sv | 28 ++
 rtl/rom_loader.sv | 110 +++++++++++
 2 files changed

// File: rtl/icehack_pkg.sv
// Shared definitions for the icehack boot path: default loader geometry,
// loader state encoding and the word-count clamp.
package icehack_pkg;

    localparam int DEF_WORD_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 15;

    typedef enum logic [2:0] {
        COUNT_HI,
        COUNT_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        DONE
    } loader_state_e;

    // Limits a received 16-bit word count to the memory capacity 2^addr_width.
    function automatic int clamp_count(input logic [15:0] received, input int addr_width);
        int capacity;
        capacity = 0;
        if (addr_width >= 16) begin
            return int'(received);
        end
        capacity = 1 << addr_width;
        return (int'(received) > capacity) ? capacity : int'(received);
    endfunction

endpackage

// File: rtl/rom_loader.sv
// Byte-stream ROM image loader: reads a 16-bit word count and then that many
// big-endian words, writing each into downstream memory while holding the CPU.
module rom_loader
    import icehack_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    input  logic                  start,
    output logic [WORD_WIDTH-1:0] out,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  load,
    output logic                  cpu_hold,
    output logic                  done
);

    // One extra bit so a full-capacity count (2^ADDR_WIDTH) is representable.
    localparam int CNT_W = ADDR_WIDTH + 1;

    loader_state_e         state_q, state_d;
    logic [7:0]            count_hi_q, count_hi_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic        accept;
    logic [15:0] received;
    logic [CNT_W-1:0] next_index;

    assign accept     = byte_valid && byte_ready;
    assign received   = {count_hi_q, byte_in};
    assign next_index = {1'b0, addr_q} + CNT_W'(1);

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path through the case infers a latch.
        state_d    = state_q;
        count_hi_d = count_hi_q;
        count_d    = count_q;
        word_d     = word_q;
        addr_d     = addr_q;

        unique case (state_q)
            COUNT_HI: begin
                if (accept) begin
                    count_hi_d = byte_in;
                    state_d    = COUNT_LO;
                end
            end
            COUNT_LO: begin
                if (accept) begin
                    count_d = CNT_W'(clamp_count(received, ADDR_WIDTH));
                    state_d = (received == 16'd0) ? DONE : DATA_HI;
                end
            end
            DATA_HI, DATA_LO: begin
                // Shifting in bytes leaves {hi,lo} in the low 16 bits after the second byte.
                if (accept) begin
                    word_d  = {word_q[WORD_WIDTH-9:0], byte_in};
                    state_d = (state_q == DATA_HI) ? DATA_LO : WRITE;
                end
            end
            WRITE: begin
                if (next_index < count_q) begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = DATA_HI;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    addr_d  = '0;
                    state_d = COUNT_HI;
                end
            end
            default: state_d = COUNT_HI;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: reset wins over every in-flight state, so a partial word never reaches WRITE.
        if (reset) begin
            state_q    <= COUNT_HI;
            count_hi_q <= '0;
            count_q    <= '0;
            word_q     <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            count_hi_q <= count_hi_d;
            count_q    <= count_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
        end
    end

    assign byte_ready = (state_q == COUNT_HI) || (state_q == COUNT_LO) ||
                        (state_q == DATA_HI)  || (state_q == DATA_LO);
    assign load       = (state_q == WRITE);
    assign done       = (state_q == DONE);
    assign cpu_hold   = (state_q != DONE);
    assign out        = word_q;
    assign address    = addr_q;

endmodule
